sdq_responder: RTL and testbench

Responder end of the team's single-wire half-duplex `sdq` bus. It receives a command frame driven onto a shared `inout` line by a remote initiator and hands the command to local logic. After a turnaround gap it drives a response frame back on the same line, then releases it. It owns the responder-side tri-state driver, so it is the only block that may drive the bus from this side; a read-back check flags multi-driver contention, which shows as a mismatch or `x` in simulation.

---
 rtl/sdq_pkg.sv | 25 ++
 rtl/sdq_pad.sv | 28 ++
 rtl/sdq_responder.sv | 161 ++++++++++++++++
 tb/tb_sdq_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdq_pkg.sv
// rtl/sdq_pkg.sv - shared types and constants for the sdq responder
package sdq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_CMD,
        TURN,
        WAIT_RSP,
        TX,
        GUARD
    } sdq_state_e;

    localparam logic SDQ_START = 1'b0;
    localparam logic SDQ_STOP  = 1'b1;

    // Largest of three values; used to size the shared phase counter.
    function automatic int sdq_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sdq_pad.sv
// rtl/sdq_pad.sv - responder tri-state driver with input and read-back flops
module sdq_pad
    import sdq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic oe,
    input  logic drv,
    inout  wire  dq,
    output logic dq_q,
    output logic drv_q
);

    // The only driver of the bus from the responder side.
    assign dq = oe ? drv : 1'bz;

    // Sample the line and keep last cycle's drive bit so both refer to the same bit time.
    always_ff @(posedge clk) begin
        if (rst) begin
            dq_q  <= SDQ_STOP;
            drv_q <= SDQ_STOP;
        end else begin
            dq_q  <= dq;
            drv_q <= drv;
        end
    end

endmodule

// File: rtl/sdq_responder.sv
// rtl/sdq_responder.sv - responder end of the single-wire half-duplex sdq bus
module sdq_responder
    import sdq_pkg::*;
#(
    parameter int W       = 8,
    parameter int TURN    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire          dq,
    output logic         cmd_valid,
    output logic [W-1:0] cmd_data,
    input  logic         rsp_valid,
    output logic         rsp_ready,
    input  logic [W-1:0] rsp_data,
    output logic         busy,
    output logic         contention,
    output logic         timeout
);

    // One counter serves every phase, so it is sized for the longest one.
    localparam int CNT_MAX = sdq_max3(W + 2, TURN, TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RX_LAST   = CW'(W - 1);
    localparam logic [CW-1:0] PAY_END   = CW'(W);
    localparam logic [CW-1:0] TX_LAST   = CW'(W + 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    sdq_state_e    state;
    logic [CW-1:0] cnt;
    logic [W-2:0]  rx_sh;
    logic [W-1:0]  rx_next;
    logic [W-1:0]  tx_sh;
    logic          oe;
    logic          drv;
    logic          dq_q;
    logic          drv_q;

    sdq_pad u_pad (
        .clk   (clk),
        .rst   (rst),
        .oe    (oe),
        .drv   (drv),
        .dq    (dq),
        .dq_q  (dq_q),
        .drv_q (drv_q)
    );

    // Received bits so far plus the bit on the line this cycle.
    assign rx_next = {rx_sh, dq_q};

    // Frame sequencer: receive, turnaround, wait for local response, transmit, guard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            oe         <= 1'b0;
            drv        <= SDQ_STOP;
            cmd_data   <= '0;
            cmd_valid  <= 1'b0;
            rsp_ready  <= 1'b0;
            busy       <= 1'b0;
            contention <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            contention <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (dq_q == SDQ_START) begin
                        state <= RX_CMD;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RX_CMD: begin
                    rx_sh <= rx_next[W-2:0];
                    if (cnt == RX_LAST) begin
                        cmd_data  <= rx_next;
                        cmd_valid <= 1'b1;
                        state     <= sdq_pkg::TURN;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                sdq_pkg::TURN: begin
                    if (cnt == TURN_LAST) begin
                        state     <= WAIT_RSP;
                        cnt       <= '0;
                        rsp_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RSP: begin
                    // A handshake on the last wait cycle still wins over the timeout.
                    if (rsp_valid && rsp_ready) begin
                        tx_sh     <= rsp_data;
                        oe        <= 1'b1;
                        drv       <= SDQ_START;
                        state     <= TX;
                        cnt       <= '0;
                        rsp_ready <= 1'b0;
                    end else if (cnt == TO_LAST) begin
                        timeout   <= 1'b1;
                        rsp_ready <= 1'b0;
                        state     <= GUARD;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX: begin
                    // Read-back only from the second TX cycle on: earlier samples were not ours.
                    if ((cnt != '0) && (dq_q !== drv_q)) begin
                        contention <= 1'b1;
                        oe         <= 1'b0;
                        drv        <= SDQ_STOP;
                        state      <= GUARD;
                        cnt        <= '0;
                    end else if (cnt == TX_LAST) begin
                        oe    <= 1'b0;
                        drv   <= SDQ_STOP;
                        state <= GUARD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == PAY_END) begin
                            drv <= SDQ_STOP;
                        end else begin
                            drv   <= tx_sh[W-1];
                            tx_sh <= {tx_sh[W-2:0], 1'b0};
                        end
                    end
                end
                GUARD: begin
                    if (cnt == TURN_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    oe    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdq_responder.sv
// tb/tb_sdq_responder.sv - directed self-checking bench for sdq_responder
module tb_sdq_responder;

    logic       clk;
    logic       rst;
    logic       tb_oe;
    logic       tb_drv;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       rsp_ready;
    logic       busy;
    logic       contention;
    logic       timeout;
    wire        dq;

    int n_checks = 0;
    int n_errors = 0;
    int n_cmd    = 0;
    int n_cont   = 0;
    int n_tmo    = 0;
    logic [7:0] cmd_log [0:15];

    assign dq = tb_oe ? tb_drv : 1'bz;
    pullup (dq);

    sdq_responder #(.W(8), .TURN(2), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .dq         (dq),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .contention (contention),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse log sampled on the falling edge.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            cmd_log[n_cmd % 16] = cmd_data;
            n_cmd++;
        end
        if (contention === 1'b1) n_cont++;
        if (timeout === 1'b1) n_tmo++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start bit in the current cycle, then 8 payload bits MSB first; returns in the cycle after the last bit.
    task automatic send_frame(input logic [7:0] d);
        tb_oe  = 1'b1;
        tb_drv = 1'b0;
        tick();
        check("busy_before_detect", busy, 0);
        for (int i = 7; i >= 0; i--) begin
            tb_drv = d[i];
            if (i == 6) check("busy_at_detect", busy, 1);
            tick();
        end
        tb_oe  = 1'b0;
        tb_drv = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe"}, dut.oe, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_data"}, cmd_data, 0);
        check({tag, "_rsp_ready"}, rsp_ready, 0);
        check({tag, "_contention"}, contention, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        logic [9:0] exp_bits;
        logic       bad;
        int         base_cmd;
        int         base_cont;
        int         base_tmo;

        rst       = 1'b1;
        tb_oe     = 1'b0;
        tb_drv    = 1'b1;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Command 0xA5, response 0x3C offered three cycles into WAIT_RSP.
        send_frame(8'hA5);
        tick();
        check("a5_cmd_valid", cmd_valid, 1);
        check("a5_cmd_data", cmd_data, 8'hA5);
        tick();
        check("a5_cmd_valid_drop", cmd_valid, 0);
        check("a5_ready_in_turn", rsp_ready, 0);
        tick();
        check("a5_ready_wait", rsp_ready, 1);
        tick();
        tick();
        tick();
        rsp_data  = 8'h3C;
        rsp_valid = 1'b1;
        check("a5_released_wait", dut.oe, 0);
        tick();
        rsp_valid = 1'b0;
        check("a5_ready_after_hs", rsp_ready, 0);
        exp_bits = 10'b0001111001;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx3c_bit%0d", k), dq, exp_bits[9-k]);
            if (dut.oe !== 1'b1 || contention !== 1'b0) bad = 1'b1;
            tick();
        end
        check("tx3c_oe_contention_during_tx", bad, 0);
        check("tx3c_released", dut.oe, 0);
        check("tx3c_guard_busy", busy, 1);
        tick();
        tick();
        check("tx3c_idle", busy, 0);

        // No response: timeout 16 cycles after entering WAIT_RSP.
        send_frame(8'h81);
        tick();
        check("t_cmd_data", cmd_data, 8'h81);
        tick();
        tick();
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (timeout !== 1'b0 || dut.oe !== 1'b0 || rsp_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        check("t_wait_window", bad, 0);
        check("t_timeout_pulse", timeout, 1);
        check("t_ready_drop", rsp_ready, 0);
        tick();
        check("t_timeout_one_cycle", timeout, 0);
        check("t_guard_busy", busy, 1);
        tick();
        check("t_idle", busy, 0);
        tick();

        // Contention: rsp_valid held before WAIT_RSP, bench fights payload bit index 1.
        send_frame(8'hC3);
        rsp_data  = 8'h3C;
        rsp_valid = 1'b1;
        tick();
        tick();
        tick();
        check("c_ready_first_wait", rsp_ready, 1);
        tick();
        rsp_valid = 1'b0;
        check("c_start_driven", dut.oe, 1);
        check("c_start_bit", dq, 0);
        tick();
        tick();
        tb_oe  = 1'b1;
        tb_drv = 1'b1;
        tick();
        tb_oe  = 1'b0;
        check("c_no_pulse_yet", contention, 0);
        tick();
        check("c_contention_pulse", contention, 1);
        check("c_released", dut.oe, 0);
        tick();
        check("c_pulse_one_cycle", contention, 0);
        check("c_guard_busy", busy, 1);
        check("c_stays_released", dut.oe, 0);
        tick();
        check("c_idle", busy, 0);
        tick();

        // Reset on the 4th TX cycle.
        send_frame(8'h42);
        rsp_data  = 8'h3C;
        rsp_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rsp_valid = 1'b0;
        tick();
        tick();
        tick();
        check("r_driving_before_rst", dut.oe, 1);
        base_cont = n_cont;
        base_tmo  = n_tmo;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midtx_reset");
        tick();
        send_frame(8'h5A);
        tick();
        check("r_cmd_valid", cmd_valid, 1);
        check("r_cmd_data", cmd_data, 8'h5A);
        check("r_no_contention", n_cont - base_cont, 0);
        check("r_no_timeout", n_tmo - base_tmo, 0);
        repeat (20) tick();
        check("r_back_idle", busy, 0);

        // Back-to-back frames at minimum spacing with a response in between.
        base_cmd  = n_cmd;
        base_cont = n_cont;
        send_frame(8'h01);
        rsp_data  = 8'h99;
        rsp_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 3) rsp_valid = 1'b0;
        end
        send_frame(8'hFF);
        tick();
        check("b_second_cmd_valid", cmd_valid, 1);
        tick();
        check("b_cmd_count", n_cmd - base_cmd, 2);
        check("b_first_data", cmd_log[base_cmd % 16], 8'h01);
        check("b_second_data", cmd_log[(base_cmd + 1) % 16], 8'hFF);
        check("b_no_contention", n_cont - base_cont, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
